tgt_hdr_ddr_engine: RTL and testbench
=====================================

# tgt_hdr_ddr_engine

Target-side HDR-DDR frame engine. It is the responder-side counterpart of the controller HDR engine that sequences CCC and DDR transfers. It sits between the target's DDR word deserializer, restart/exit pattern detector and the target register file / TX path. It decodes command words, filters them by address, forwards write data, checks parity, CRC5 and preambles, and signals read starts and frame completion.

## Interface
- `MAX_WORDS`, 16: maximum data words per write frame (1..31).
- `BCAST_ADDR`, 7'h7E: broadcast address. Accepted for writes only.
- `i_sys_clk`  in  1  system clock.
- `i_sys_rst_n`  in  1  asynchronous active-low reset.
- `i_engine_en`  in  1  high while the target is in HDR-DDR mode, i.e. after ENTHDR0 is accepted.
- `i_dyn_addr`  in  7  own dynamic address.
- `i_word_valid`  in  1  one-cycle strobe that qualifies `i_word`.
- `i_word`  in  20  bits [19:18] preamble, [17:2] payload P[15:0], [1:0] parity {PA1,PA0}.
- `i_restart_det` / `i_exit_det`  in  1  one-cycle HDR restart / exit pattern strobes.
- `i_rd_done`  in  1  one-cycle strobe from target TX: read data and CRC have been sent.
- `o_cmd_valid`  out  1  pulse when an addressed command is accepted.
- `o_cmd_rnw`  out  1  RnW bit of the command. Held until the next command.
- `o_cmd_code`  out  7  command code. Held until the next command.
- `o_wr_valid`  out  1  pulse per accepted write data word.
- `o_wr_data`  out  16  payload of the write data word.
- `o_rd_start`  out  1  pulse that tells TX to start a read response.
- `o_frame_done`  out  1  pulse at the end of an addressed frame.
- `o_err_parity`, `o_err_crc`, `o_err_frame`, `o_err_ovf`  out  1  error pulses.
- `o_engine_done`  out  1  pulse on HDR exit.

## Operation
- All outputs are registered. Every output resets to 0.
- Parity check:
  - PA1 = ^P[15,13,11,9,7,5,3,1]
  - PA0 = ^P[14,12,10,8,6,4,2,0] ^ 1
  - A mismatch pulses `o_err_parity` and moves the FSM to SKIP.
- Command word: preamble 2'b01. Fields are RnW=P[15], code=P[14:8], addr=P[7:1].
- Data word: preamble 2'b10.
- CRC word: preamble 2'b01, P[15:12]=4'hC, crc5=P[11:7].
- CRC5 uses polynomial x^5+x^2+1, seed 5'h1F.
  - The seed is reloaded on each command.
  - Each data payload is processed MSB first, one bit per step: fb=crc[4]^d; crc={crc[3:0],1'b0}^(fb?5'b00101:0).
  - All 16 bits of a word fold in the same cycle.
- FSM states: IDLE, WAIT_CMD, WR_DATA, RD_WAIT, END, SKIP.
  - IDLE: when `i_engine_en` rises, go to WAIT_CMD.
  - WAIT_CMD, on a valid command word:
    - addr==`i_dyn_addr`: accept the command. If RnW=0, go to WR_DATA. If RnW=1, pulse `o_rd_start` and go to RD_WAIT.
    - addr==BCAST_ADDR and RnW=0: accept the command and go to WR_DATA.
    - Any other address: go to SKIP with no outputs.
    - Wrong preamble: pulse `o_err_frame` and go to SKIP.
  - WR_DATA:
    - Data word: pulse `o_wr_valid` and increment the word count. If the count would exceed MAX_WORDS, pulse `o_err_ovf` instead of `o_wr_valid` and go to SKIP.
    - CRC word: pulse `o_frame_done`. Also pulse `o_err_crc` in the same cycle if the token or CRC mismatches. Then go to END.
  - RD_WAIT: on `i_rd_done`, pulse `o_frame_done` and go to END. Words received in this state are ignored.
  - END: any word pulses `o_err_frame` and moves the FSM to SKIP.
  - SKIP: ignore all words.
- From any state except IDLE:
  - `i_restart_det`: go to WAIT_CMD.
  - `i_exit_det`: go to IDLE and pulse `o_engine_done`.
- Priority for simultaneous events: `i_engine_en` low > exit > restart > word.
- A restart or exit during WR_DATA or RD_WAIT ends the frame without `o_frame_done`.
- Dropping `i_engine_en`:
  - Forces IDLE on the next edge and clears the counter and CRC.
  - Produces no `o_engine_done`.
  - Words received in IDLE are ignored.

## Timing
- All output pulses are exactly one cycle wide.
- Each pulse appears on the clock edge after the triggering strobe: a 1-cycle latency.
- `o_wr_data` is valid in the same cycle as `o_wr_valid`.
- `o_cmd_code` and `o_cmd_rnw` update together with `o_cmd_valid`.
- `o_rd_start` is coincident with `o_cmd_valid`.
- Back-to-back `i_word_valid` (every cycle) is supported without loss.
- The CRC register and word counter update on the same edge as `o_wr_valid`.
- Asynchronous reset mid-frame clears all state and outputs immediately.

## Test plan
- Enable, addr=`i_dyn_addr`=7'h12, write cmd code 7'h20, data 16'h0000, CRC word with crc5=5'h01:
  - `o_cmd_valid` pulses with code 7'h20, rnw 0.
  - `o_wr_valid` pulses with data 16'h0000.
  - `o_frame_done` pulses. No error pulse.
- Same frame with crc5=5'h02: `o_frame_done` and `o_err_crc` pulse in the same cycle.
- Read cmd to 7'h12: `o_cmd_valid` and `o_rd_start` pulse; a later `i_rd_done` produces `o_frame_done`.
- Cmd to 7'h33, then data words, then restart: no outputs. A following cmd to 7'h12 is accepted.
- 17 data words with MAX_WORDS=16: 16 `o_wr_valid` pulses, then `o_err_ovf`, then no `o_frame_done`.
- Data word with PA0 flipped: `o_err_parity` pulses. Then `i_exit_det`: `o_engine_done` pulses, FSM returns to IDLE. Simultaneous restart and exit: exit wins.

Source files
------------

// File: rtl/tgt_hdr_ddr_if.sv
// tgt_hdr_ddr_if: word stream, control strobes and result pulses of the target HDR-DDR engine
interface tgt_hdr_ddr_if;
  logic i_engine_en;
  logic [6:0] i_dyn_addr;
  logic i_word_valid;
  logic [19:0] i_word;
  logic i_restart_det;
  logic i_exit_det;
  logic i_rd_done;
  logic o_cmd_valid;
  logic o_cmd_rnw;
  logic [6:0] o_cmd_code;
  logic o_wr_valid;
  logic [15:0] o_wr_data;
  logic o_rd_start;
  logic o_frame_done;
  logic o_err_parity;
  logic o_err_crc;
  logic o_err_frame;
  logic o_err_ovf;
  logic o_engine_done;
  modport master (
    output i_engine_en, i_dyn_addr, i_word_valid, i_word, i_restart_det, i_exit_det, i_rd_done,
    input o_cmd_valid, o_cmd_rnw, o_cmd_code, o_wr_valid, o_wr_data, o_rd_start, o_frame_done,
    input o_err_parity, o_err_crc, o_err_frame, o_err_ovf, o_engine_done
  );
  modport slave (
    input i_engine_en, i_dyn_addr, i_word_valid, i_word, i_restart_det, i_exit_det, i_rd_done,
    output o_cmd_valid, o_cmd_rnw, o_cmd_code, o_wr_valid, o_wr_data, o_rd_start, o_frame_done,
    output o_err_parity, o_err_crc, o_err_frame, o_err_ovf, o_engine_done
  );
endinterface

// File: rtl/tgt_hdr_ddr_engine.sv
// tgt_hdr_ddr_engine: target-side HDR-DDR frame decoder with address filter, parity, CRC5 and preamble checks
module tgt_hdr_ddr_engine #(
  parameter int MAX_WORDS = 16,
  parameter logic [6:0] BCAST_ADDR = 7'h7E
) (
  input logic i_sys_clk,
  input logic i_sys_rst_n,
  tgt_hdr_ddr_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_CMD, WR_DATA, RD_WAIT, END, SKIP} state_t;
  state_t state, state_n;
  logic en_q;
  logic [4:0] crc, crc_n, crc_fold;
  logic [5:0] cnt, cnt_n;
  logic cmd_v, rd_s, wr_v, f_done, e_par, e_crc, e_frm, e_ovf, e_done;
  logic [1:0] pre;
  logic [15:0] p;
  logic par_ok;
  assign pre = bus.i_word[19:18];
  assign p = bus.i_word[17:2];
  assign par_ok = bus.i_word[1:0] == {^(p & 16'hAAAA), ~^(p & 16'h5555)};
  // whole payload folded MSB first in one cycle
  always_comb begin
    crc_fold = crc;
    for (int i = 15; i >= 0; i--)
      crc_fold = {crc_fold[3:0], 1'b0} ^ ((crc_fold[4] ^ p[i]) ? 5'b00101 : 5'b00000);
  end
  always_comb begin
    state_n = state;
    crc_n = crc;
    cnt_n = cnt;
    cmd_v = 1'b0;
    rd_s = 1'b0;
    wr_v = 1'b0;
    f_done = 1'b0;
    e_par = 1'b0;
    e_crc = 1'b0;
    e_frm = 1'b0;
    e_ovf = 1'b0;
    e_done = 1'b0;
    if (!bus.i_engine_en) begin
      state_n = IDLE;
      crc_n = '0;
      cnt_n = '0;
    end else if (state == IDLE) state_n = en_q ? IDLE : WAIT_CMD;
    else if (bus.i_exit_det) begin
      state_n = IDLE;
      e_done = 1'b1;
    end else if (bus.i_restart_det) state_n = WAIT_CMD;
    else if (state == RD_WAIT) begin
      f_done = bus.i_rd_done;
      state_n = bus.i_rd_done ? END : RD_WAIT;
    end else if (bus.i_word_valid) begin
      case (state)
        WAIT_CMD:
          if (!par_ok) begin
            e_par = 1'b1;
            state_n = SKIP;
          end else if (pre != 2'b01) begin
            e_frm = 1'b1;
            state_n = SKIP;
          end else if (p[7:1] == bus.i_dyn_addr || (p[7:1] == BCAST_ADDR && !p[15])) begin
            cmd_v = 1'b1;
            rd_s = p[15];
            crc_n = 5'h1F;
            cnt_n = '0;
            state_n = p[15] ? RD_WAIT : WR_DATA;
          end else state_n = SKIP;
        WR_DATA:
          if (!par_ok) begin
            e_par = 1'b1;
            state_n = SKIP;
          end else if (pre == 2'b10) begin
            e_ovf = cnt == 6'(MAX_WORDS);
            wr_v = !e_ovf;
            cnt_n = e_ovf ? cnt : cnt + 6'd1;
            crc_n = e_ovf ? crc : crc_fold;
            state_n = e_ovf ? SKIP : WR_DATA;
          end else if (pre == 2'b01) begin
            f_done = 1'b1;
            e_crc = p[15:12] != 4'hC || p[11:7] != crc;
            state_n = END;
          end else begin
            e_frm = 1'b1;
            state_n = SKIP;
          end
        END: begin
          e_frm = 1'b1;
          state_n = SKIP;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n)
    if (!i_sys_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n)
    if (!i_sys_rst_n) begin
      en_q <= 1'b0;
      crc <= '0;
      cnt <= '0;
      bus.o_cmd_valid <= 1'b0;
      bus.o_cmd_rnw <= 1'b0;
      bus.o_cmd_code <= '0;
      bus.o_wr_valid <= 1'b0;
      bus.o_wr_data <= '0;
      bus.o_rd_start <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_err_parity <= 1'b0;
      bus.o_err_crc <= 1'b0;
      bus.o_err_frame <= 1'b0;
      bus.o_err_ovf <= 1'b0;
      bus.o_engine_done <= 1'b0;
    end else begin
      en_q <= bus.i_engine_en;
      crc <= crc_n;
      cnt <= cnt_n;
      bus.o_cmd_valid <= cmd_v;
      bus.o_cmd_rnw <= cmd_v ? p[15] : bus.o_cmd_rnw;
      bus.o_cmd_code <= cmd_v ? p[14:8] : bus.o_cmd_code;
      bus.o_wr_valid <= wr_v;
      bus.o_wr_data <= wr_v ? p : bus.o_wr_data;
      bus.o_rd_start <= rd_s;
      bus.o_frame_done <= f_done;
      bus.o_err_parity <= e_par;
      bus.o_err_crc <= e_crc;
      bus.o_err_frame <= e_frm;
      bus.o_err_ovf <= e_ovf;
      bus.o_engine_done <= e_done;
    end
endmodule

// File: tb/tb_tgt_hdr_ddr_engine.sv
// tb_tgt_hdr_ddr_engine: directed test-plan frames plus randomized frames scored against frame-level expectations
module tb_tgt_hdr_ddr_engine;
  localparam int MAXW = 16;
  localparam logic [6:0] OWN = 7'h12;
  localparam logic [6:0] BC = 7'h7E;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tgt_hdr_ddr_if bus();
  tgt_hdr_ddr_engine #(.MAX_WORDS(MAXW), .BCAST_ADDR(BC)) dut (
    .i_sys_clk(clk),
    .i_sys_rst_n(rst_n),
    .bus(bus)
  );
  int n_chk = 0;
  int n_err = 0;
  int m_cmd = 0, m_rd = 0, m_wr = 0, m_fd = 0, m_par = 0, m_crc = 0, m_frm = 0, m_ovf = 0, m_done = 0, m_bad = 0;
  logic [15:0] wr_log [0:4095];
  always @(negedge clk) begin
    if (bus.o_cmd_valid) m_cmd++;
    if (bus.o_rd_start) m_rd++;
    if (bus.o_frame_done) m_fd++;
    if (bus.o_err_parity) m_par++;
    if (bus.o_err_crc) m_crc++;
    if (bus.o_err_frame) m_frm++;
    if (bus.o_err_ovf) m_ovf++;
    if (bus.o_engine_done) m_done++;
    if (bus.o_rd_start && !bus.o_cmd_valid) m_bad++;
    if (bus.o_err_crc && !bus.o_frame_done) m_bad++;
    if (bus.o_wr_valid && m_wr < 4096) begin
      wr_log[m_wr] = bus.o_wr_data;
      m_wr++;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {bus.o_cmd_valid, bus.o_cmd_rnw, bus.o_cmd_code, bus.o_wr_valid, bus.o_wr_data, bus.o_rd_start,
            bus.o_frame_done, bus.o_err_parity, bus.o_err_crc, bus.o_err_frame, bus.o_err_ovf, bus.o_engine_done};
  endfunction
  function automatic logic [19:0] mk(input logic [1:0] pre, input logic [15:0] p);
    logic o, e;
    o = 1'b0;
    e = 1'b1;
    for (int i = 0; i < 16; i++)
      if (i % 2 == 1) o ^= p[i];
      else e ^= p[i];
    return {pre, p, o, e};
  endfunction
  function automatic logic [19:0] cmdw(input logic rnw, input logic [6:0] code, input logic [6:0] addr);
    return mk(2'b01, {rnw, code, addr, 1'b0});
  endfunction
  function automatic logic [19:0] datw(input logic [15:0] d);
    return mk(2'b10, d);
  endfunction
  function automatic logic [19:0] crcw(input logic [4:0] c);
    return mk(2'b01, {4'hC, c, 7'h00});
  endfunction
  function automatic logic [4:0] crc_ref(input logic [15:0] q[$], input int n);
    int c;
    c = 31;
    for (int k = 0; k < n; k++)
      for (int b = 15; b >= 0; b--)
        c = ((c << 1) & 31) ^ ((((c >> 4) & 1) ^ int'(q[k][b])) != 0 ? 5 : 0);
    return 5'(c);
  endfunction
  task automatic step(input logic wv, input logic [19:0] w, input logic rs, input logic ex, input logic rd);
    bus.i_word_valid = wv;
    bus.i_word = w;
    bus.i_restart_det = rs;
    bus.i_exit_det = ex;
    bus.i_rd_done = rd;
    @(posedge clk);
    #1;
    bus.i_word_valid = 1'b0;
    bus.i_restart_det = 1'b0;
    bus.i_exit_det = 1'b0;
    bus.i_rd_done = 1'b0;
  endtask
  task automatic word(input logic [19:0] w);
    step(1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic send(input logic [19:0] w);
    word(w);
    if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
  endtask
  initial begin
    logic [19:0] w;
    logic [15:0] q[$];
    logic [6:0] code, addr;
    logic rnw, good;
    logic [4:0] c;
    int kind, n, acc, s_wr, s_all;
    int s_cmd, s_rd, s_fd, s_par, s_crc, s_frm, s_ovf, s_done;
    int x_cmd, x_rd, x_wr, x_fd, x_par, x_crc, x_frm, x_ovf;
    bus.i_engine_en = 1'b0;
    bus.i_dyn_addr = OWN;
    bus.i_word_valid = 1'b0;
    bus.i_word = '0;
    bus.i_restart_det = 1'b0;
    bus.i_exit_det = 1'b0;
    bus.i_rd_done = 1'b0;
    #13;
    chk("reset_outputs", outs(), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_engine_en = 1'b1;
    idle(1);
    word(cmdw(1'b0, 7'h20, OWN));
    chk("wr_cmd_valid", bus.o_cmd_valid, 1);
    chk("wr_cmd_code", bus.o_cmd_code, 7'h20);
    chk("wr_cmd_rnw", bus.o_cmd_rnw, 0);
    word(datw(16'h0000));
    chk("wr_valid", bus.o_wr_valid, 1);
    chk("wr_data", bus.o_wr_data, 16'h0000);
    chk("cmd_pulse_width", bus.o_cmd_valid, 0);
    word(crcw(5'h01));
    chk("good_crc_done", bus.o_frame_done, 1);
    chk("good_crc_noerr", {bus.o_err_crc, bus.o_err_parity, bus.o_err_frame, bus.o_err_ovf}, 0);
    chk("wr_pulse_width", bus.o_wr_valid, 0);
    step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    word(cmdw(1'b0, 7'h20, OWN));
    word(datw(16'h0000));
    word(crcw(5'h02));
    chk("bad_crc_pair", {bus.o_frame_done, bus.o_err_crc}, 2'b11);
    step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    word(cmdw(1'b1, 7'h05, OWN));
    chk("rd_cmd", {bus.o_cmd_valid, bus.o_rd_start, bus.o_cmd_rnw, bus.o_cmd_code}, {3'b111, 7'h05});
    word(datw(16'hBEEF));
    idle(3);
    chk("rd_wait_quiet", {bus.o_frame_done, bus.o_wr_valid, bus.o_rd_start}, 0);
    step(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    chk("rd_done_frame", bus.o_frame_done, 1);
    step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    s_all = m_cmd + m_rd + m_wr + m_fd + m_par + m_crc + m_frm + m_ovf + m_done;
    word(cmdw(1'b0, 7'h01, 7'h33));
    word(datw(16'h0001));
    word(datw(16'h0002));
    step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("foreign_quiet", m_cmd + m_rd + m_wr + m_fd + m_par + m_crc + m_frm + m_ovf + m_done - s_all, 0);
    word(cmdw(1'b0, 7'h21, OWN));
    chk("after_foreign_cmd", {bus.o_cmd_valid, bus.o_cmd_code}, {1'b1, 7'h21});
    s_wr = m_wr;
    for (int i = 0; i < MAXW; i++) word(datw(16'(i + 100)));
    word(datw(16'h0017));
    chk("ovf_pulse", {bus.o_err_ovf, bus.o_wr_valid}, 2'b10);
    word(crcw(5'h00));
    chk("ovf_no_done", bus.o_frame_done, 0);
    idle(1);
    chk("ovf_wr_count", m_wr - s_wr, MAXW);
    step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    word(cmdw(1'b0, 7'h22, OWN));
    w = datw(16'h1234);
    w[0] = ~w[0];
    word(w);
    chk("parity_err", {bus.o_err_parity, bus.o_wr_valid}, 2'b10);
    step(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
    chk("exit_done", bus.o_engine_done, 1);
    word(cmdw(1'b0, 7'h22, OWN));
    chk("idle_ignores_cmd", bus.o_cmd_valid, 0);
    bus.i_engine_en = 1'b0;
    idle(1);
    bus.i_engine_en = 1'b1;
    idle(1);
    step(1'b0, 20'h0, 1'b1, 1'b1, 1'b0);
    chk("exit_beats_restart", bus.o_engine_done, 1);
    word(cmdw(1'b0, 7'h23, OWN));
    chk("exit_went_idle", bus.o_cmd_valid, 0);
    bus.i_engine_en = 1'b0;
    idle(1);
    bus.i_engine_en = 1'b1;
    idle(1);
    word(cmdw(1'b0, 7'h24, OWN));
    word(datw(16'h5555));
    bus.i_engine_en = 1'b0;
    idle(1);
    chk("en_drop_quiet", {bus.o_engine_done, bus.o_frame_done}, 0);
    bus.i_engine_en = 1'b1;
    idle(1);
    word(cmdw(1'b0, 7'h25, OWN));
    chk("reenable_cmd", {bus.o_cmd_valid, bus.o_cmd_code}, {1'b1, 7'h25});
    word(datw(16'hA5A5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int f = 0; f < 60; f++) begin
      kind = int'($urandom_range(0, 5));
      s_cmd = m_cmd; s_rd = m_rd; s_wr = m_wr; s_fd = m_fd; s_par = m_par;
      s_crc = m_crc; s_frm = m_frm; s_ovf = m_ovf; s_done = m_done;
      x_cmd = 0; x_rd = 0; x_wr = 0; x_fd = 0; x_par = 0; x_crc = 0; x_frm = 0; x_ovf = 0;
      q.delete();
      code = 7'($urandom);
      rnw = 1'b0;
      if (kind <= 1 || kind >= 4) begin
        x_cmd = 1;
        send(cmdw(1'b0, code, kind == 1 ? BC : OWN));
        n = kind == 4 ? int'($urandom_range(0, 4)) : kind == 5 ? int'($urandom_range(1, 4)) : int'($urandom_range(0, MAXW + 2));
        for (int i = 0; i < n; i++) q.push_back(16'($urandom));
        acc = n > MAXW ? MAXW : n;
        x_wr = acc;
        x_ovf = n > MAXW ? 1 : 0;
        foreach (q[i]) send(datw(q[i]));
        if (kind == 4) begin
          w = datw(16'($urandom));
          w[$urandom_range(0, 1)] ^= 1'b1;
          send(w);
          x_par = 1;
          send(datw(16'($urandom)));
          send(crcw(crc_ref(q, acc)));
        end else begin
          good = kind == 5 || $urandom_range(0, 3) != 0;
          c = crc_ref(q, acc);
          if (!good) c ^= 5'($urandom_range(1, 31));
          if (kind == 5 || $urandom_range(0, 4) != 0) begin
            send(crcw(c));
            x_fd = x_ovf ? 0 : 1;
            x_crc = (x_ovf == 0 && !good) ? 1 : 0;
          end
          if (kind == 5) begin
            send(datw(16'($urandom)));
            x_frm = 1;
          end
        end
      end else if (kind == 2) begin
        rnw = 1'b1;
        x_cmd = 1;
        x_rd = 1;
        send(cmdw(1'b1, code, OWN));
        repeat ($urandom_range(0, 3)) send(20'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          step(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
          x_fd = 1;
        end
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          addr = BC;
          rnw = 1'b1;
        end else begin
          addr = 7'($urandom);
          while (addr == OWN || addr == BC) addr = 7'($urandom);
          rnw = 1'($urandom);
        end
        send(cmdw(rnw, code, addr));
        repeat ($urandom_range(0, 4)) send(datw(16'($urandom)));
      end
      step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk($sformatf("f%0d_cmd", f), m_cmd - s_cmd, x_cmd);
      chk($sformatf("f%0d_rd_start", f), m_rd - s_rd, x_rd);
      chk($sformatf("f%0d_wr_count", f), m_wr - s_wr, x_wr);
      chk($sformatf("f%0d_frame_done", f), m_fd - s_fd, x_fd);
      chk($sformatf("f%0d_errs", f), {8'(m_par - s_par), 8'(m_crc - s_crc), 8'(m_frm - s_frm), 8'(m_ovf - s_ovf)},
          {8'(x_par), 8'(x_crc), 8'(x_frm), 8'(x_ovf)});
      chk($sformatf("f%0d_engine_done", f), m_done - s_done, 0);
      if (x_cmd == 1) chk($sformatf("f%0d_cmd_fields", f), {bus.o_cmd_rnw, bus.o_cmd_code}, {rnw, code});
      if (m_wr - s_wr == x_wr)
        for (int i = 0; i < x_wr; i++) chk($sformatf("f%0d_wr_data%0d", f, i), wr_log[s_wr + i], q[i]);
    end
    chk("pulse_coincidence", m_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
